serial_pattern_generator: RTL and testbench

Transmit-side counterpart of the team's serial pattern detector. Accepts a parallel pattern word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, repeated a programmable number of times. It drives the serial bit-stream that the detector consumes, both in test harnesses and on-chip loopback.

---
 rtl/serial_pattern_generator_if.sv | 31 +++
 rtl/serial_pattern_generator.sv | 133 +++++++++++++
 tb/tb_serial_pattern_generator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_generator_if.sv
// Bundle for the serial pattern generator: pattern-word handshake plus the
// serial stream and status outputs. master drives words in, slave is the
// generator.
//
// Handshake: a word transfers on a rising clk edge where pat_valid and
// pat_ready are both high; pattern and reps are sampled only on that edge.
// out is meaningful only while out_valid is high.
interface serial_pattern_generator_if #(
    parameter int WIDTH = 3,
    parameter int REP_W = 4
);
    logic             pat_valid;
    logic             pat_ready;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output pat_valid, pattern, reps, abort,
        input  pat_ready, out, out_valid, busy, done
    );

    modport slave (
        input  pat_valid, pattern, reps, abort,
        output pat_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_generator.sv
// Serial pattern generator: accepts a WIDTH-bit word and shifts it out
// MSB-first, one bit per clock, repeated reps times (reps=0 acts as 1).
// Optional macro PATTERN_GEN_PARITY_EN appends an even-parity bit after
// every repetition (extra PAR state).
// dbg_state exposes the FSM state for observation.
module serial_pattern_generator #(
    parameter int WIDTH = 3,
    parameter int REP_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_pattern_generator_if.slave   bus,
    output logic [1:0]                  dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef PATTERN_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] pat_reg;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [REP_W-1:0] rep_cnt;

    assign bus.pat_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;

    // FSM with registered serial outputs: load, shift, repeat, finish or abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pat_reg       <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            rep_cnt       <= '0;
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is ignored here, so it never blocks a handshake
                    bus.out       <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.done      <= 1'b0;
                    if (bus.pat_valid) begin
                        pat_reg       <= bus.pattern;
                        rep_cnt       <= (bus.reps == '0) ? REP_W'(1) : bus.reps;
                        bus.out       <= bus.pattern[WIDTH-1];
                        bus.out_valid <= 1'b1;
                        shreg         <= bus.pattern << 1;
                        bit_cnt       <= CW'(1);
                        state         <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.out       <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.done      <= 1'b0;
                    end else if (bit_cnt != CW'(WIDTH)) begin
                        bus.out <= shreg[WIDTH-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CW'(1);
`ifdef PATTERN_GEN_PARITY_EN
                        // the parity bit, not a data bit, closes the transfer
                        bus.done <= 1'b0;
`else
                        bus.done <= (bit_cnt == CW'(WIDTH - 1)) && (rep_cnt == REP_W'(1));
`endif
                    end else begin
`ifdef PATTERN_GEN_PARITY_EN
                        state    <= PAR;
                        bus.out  <= ^pat_reg;
                        bus.done <= (rep_cnt == REP_W'(1));
`else
                        if (rep_cnt > REP_W'(1)) begin
                            // next repetition starts with no gap
                            rep_cnt  <= rep_cnt - REP_W'(1);
                            bus.out  <= pat_reg[WIDTH-1];
                            shreg    <= pat_reg << 1;
                            bit_cnt  <= CW'(1);
                            bus.done <= 1'b0;
                        end else begin
                            state         <= IDLE;
                            bus.out       <= 1'b0;
                            bus.out_valid <= 1'b0;
                            bus.done      <= 1'b0;
                        end
`endif
                    end
                end

`ifdef PATTERN_GEN_PARITY_EN
                PAR: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.out       <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.done      <= 1'b0;
                    end else if (rep_cnt > REP_W'(1)) begin
                        state    <= SHIFT;
                        rep_cnt  <= rep_cnt - REP_W'(1);
                        bus.out  <= pat_reg[WIDTH-1];
                        shreg    <= pat_reg << 1;
                        bit_cnt  <= CW'(1);
                        bus.done <= 1'b0;
                    end else begin
                        state         <= IDLE;
                        bus.out       <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.done      <= 1'b0;
                    end
                end
`endif

                default: begin
                    state         <= IDLE;
                    bus.out       <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: directed cases plus random words,
// expected bit stream built from the pattern/reps rules and popped by a
// monitor on every valid output cycle.
module tb_serial_pattern_generator;
    localparam int WIDTH = 3;
    localparam int REP_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    serial_pattern_generator_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

    serial_pattern_generator #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_q[$];          // {done, bit}
    logic [1:0] mon_e;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference stream: reps (0 means 1) copies of the word MSB first,
    // optionally followed by its even parity; done marks the final entry.
    task automatic push_model(input logic [WIDTH-1:0] p, input logic [REP_W-1:0] r);
        int         n;
        logic [1:0] t;
        n = (r == 0) ? 1 : int'(r);
        for (int k = 0; k < n; k++) begin
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({1'b0, p[i]});
`ifdef PATTERN_GEN_PARITY_EN
            exp_q.push_back({1'b0, ^p});
`endif
        end
        t = exp_q.pop_back();
        exp_q.push_back({1'b1, t[0]});
    endtask

    // monitor: compare every valid output cycle against the queue
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected valid bit out=%0b done=%0b", bus.out, bus.done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.done, bus.out, bus.pat_ready} !== {mon_e, 1'b0}) begin
                        errors++;
                        $display("FAIL stream: got done/out/ready=%b%b%b, expected %b%b0",
                                 bus.done, bus.out, bus.pat_ready, mon_e[1], mon_e[0]);
                    end
                end
                if (prev_done) begin
                    checks++;
                    errors++;
                    $display("FAIL gap: out_valid=1 right after done, expected 0");
                end
            end else if (bus.done || bus.out) begin
                checks++;
                errors++;
                $display("FAIL idle_outputs: done=%0b out=%0b with out_valid=0, expected 0",
                         bus.done, bus.out);
            end
            prev_done = bus.done;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send(input logic [WIDTH-1:0] p, input logic [REP_W-1:0] r, input logic ab);
        int waitc = 0;
        while (!bus.pat_ready && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("ready_wait", waitc < 200, 1);
        bus.pattern   = p;
        bus.reps      = r;
        bus.pat_valid = 1'b1;
        bus.abort     = ab;
        push_model(p, r);
        @(posedge clk); #1;
        bus.pat_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.pattern   = WIDTH'($urandom);
        bus.reps      = REP_W'($urandom);
        check("latency_valid", bus.out_valid, 1);
        check("first_bit", bus.out, p[WIDTH-1]);
        check("ready_low", bus.pat_ready, 0);
        check("busy_high", bus.busy, 1);
    endtask

    task automatic wait_idle();
        int waitc = 0;
        while (bus.busy && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("idle_wait", waitc < 200, 1);
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_q.delete();
        check("abort_valid", bus.out_valid, 0);
        check("abort_done", bus.done, 0);
        check("abort_ready", bus.pat_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] rp;
        logic [REP_W-1:0] rr;
        bus.pat_valid = 1'b0;
        bus.pattern   = '0;
        bus.reps      = '0;
        bus.abort     = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.pat_ready, 1);

        // single 101, then 101 x3, reps=0, 110 x2
        send(3'b101, 4'd1, 1'b0); wait_idle();
        send(3'b101, 4'd3, 1'b0); wait_idle();
        check("ready_after", bus.pat_ready, 1);
        send(3'b101, 4'd0, 1'b0); wait_idle();
        send(3'b110, 4'd2, 1'b0); wait_idle();

        // abort while the second bit is on out, then handshake with abort high in IDLE
        send(3'b101, 4'd2, 1'b0);
        @(posedge clk); #1;
        check("abort_setup_bit2", bus.out, 0);
        do_abort();
        send(3'b110, 4'd1, 1'b1); wait_idle();

        // asynchronous reset mid-repetition
        send(3'b101, 4'd3, 1'b0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out", bus.out, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        send(3'b101, 4'd1, 1'b0); wait_idle();

`ifdef PATTERN_GEN_PARITY_EN
        send(3'b100, 4'd1, 1'b0); wait_idle();
`endif

        // random words, back-to-back requests and occasional aborts
        for (int it = 0; it < 30; it++) begin
            rp = WIDTH'($urandom);
            rr = REP_W'($urandom_range(0, 3));
            send(rp, rr, 1'b0);
            repeat ($urandom_range(0, 8)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 3) == 0) do_abort();
            wait_idle();
        end

        repeat (3) begin @(posedge clk); #1; end
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
